// File: rtl/cpu_clk_ctrl_if.sv
// Handshake bundle between the board control front end and its consumers:
// raw operator inputs in, CPU clock enable, cycle count and display strobes out.
interface cpu_clk_ctrl_if;
  logic        btn_step;
  logic        run;
  logic        halt;
  logic        cpu_en;
  logic [31:0] cycle_cnt;
  logic        scan_tick;
  logic        scroll_tick;
  logic        running;
  logic        halted;

  modport master (
    output btn_step, run, halt,
    input  cpu_en, cycle_cnt, scan_tick, scroll_tick, running, halted
  );

  modport slave (
    input  btn_step, run, halt,
    output cpu_en, cycle_cnt, scan_tick, scroll_tick, running, halted
  );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// Single-cycle MIPS clock front end: step/run/halt control of the CPU clock enable,
// executed-cycle counter and free-running display scan/scroll strobes.
module cpu_clk_ctrl #(
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned SCROLL_DIV = 50000000,
  parameter int unsigned RUN_DIV    = 25000000,
  parameter int unsigned DB_CYCLES  = 1000000
) (
  input  logic          clk,
  input  logic          rst,
  cpu_clk_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STEP   = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  localparam int SCAN_W   = $clog2(SCAN_DIV);
  localparam int SCROLL_W = $clog2(SCROLL_DIV);
  localparam int RUN_W    = $clog2(RUN_DIV);
  localparam int DB_W     = $clog2(DB_CYCLES + 1);

  localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_DIV - 1);
  localparam logic [RUN_W-1:0]    RUN_LAST    = RUN_W'(RUN_DIV - 1);
  localparam logic [DB_W-1:0]     DB_LAST     = DB_W'(DB_CYCLES - 1);

  logic btn_meta, btn_sync, run_meta, run_s;
  logic [DB_W-1:0] db_cnt;
  logic db_level, step_req;

  logic [1:0]       state, state_nxt;
  logic [RUN_W-1:0] run_div, run_div_nxt;
  logic             pulse_nxt;
  logic             cpu_en_q, running_q, halted_q;
  logic [31:0]      cnt_q;

  logic [SCAN_W-1:0]   scan_div;
  logic [SCROLL_W-1:0] scroll_div;

  // NOTE: every flop uses non-blocking assignment and an async reset term in the
  // sensitivity list, so reset clears state without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      run_meta <= 1'b0;
      run_s    <= 1'b0;
    end else begin
      btn_meta <= bus.btn_step;
      btn_sync <= btn_meta;
      run_meta <= bus.run;
      run_s    <= run_meta;
    end
  end

  // Level flips on the DB_CYCLES-th consecutive sample that disagrees with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
      step_req <= 1'b0;
    end else begin
      step_req <= 1'b0;
      if (btn_sync == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt   <= '0;
        db_level <= btn_sync;
        step_req <= btn_sync;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // NOTE: defaults at the top of always_comb keep every path assigned, so no
  // latches are inferred when a case arm leaves a signal alone.
  always_comb begin
    state_nxt   = state;
    run_div_nxt = run_div;
    case (state)
      IDLE: begin
        run_div_nxt = '0;
        if (bus.halt)    state_nxt = HALTED;
        else if (run_s)  state_nxt = RUN;
        else if (step_req) state_nxt = STEP;
      end
      STEP: state_nxt = bus.halt ? HALTED : IDLE;
      RUN: begin
        if (bus.halt) begin
          state_nxt   = HALTED;
          run_div_nxt = '0;
        end else if (!run_s) begin
          state_nxt   = IDLE;
          run_div_nxt = '0;
        end else begin
          run_div_nxt = (run_div == RUN_LAST) ? '0 : run_div + 1'b1;
        end
      end
      default: state_nxt = HALTED;
    endcase
  end

  // Entry into RUN loads run_div_nxt=0, which never equals RUN_LAST (RUN_DIV>=2).
  assign pulse_nxt = (state_nxt == STEP) ||
                     ((state_nxt == RUN) && (run_div_nxt == RUN_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      run_div   <= '0;
      cpu_en_q  <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      run_div   <= run_div_nxt;
      cpu_en_q  <= pulse_nxt;
      running_q <= (state_nxt == RUN);
      halted_q  <= (state_nxt == HALTED);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cnt_q <= '0;
    else if (cpu_en_q) cnt_q <= cnt_q + 32'd1;
  end

  // Display strobes are decoded from free-running dividers, independent of the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_div   <= '0;
      scroll_div <= '0;
    end else begin
      scan_div   <= (scan_div == SCAN_LAST) ? '0 : scan_div + 1'b1;
      scroll_div <= (scroll_div == SCROLL_LAST) ? '0 : scroll_div + 1'b1;
    end
  end

  assign bus.cpu_en      = cpu_en_q;
  assign bus.cycle_cnt   = cnt_q;
  assign bus.scan_tick   = (scan_div == SCAN_LAST);
  assign bus.scroll_tick = (scroll_div == SCROLL_LAST);
  assign bus.running     = running_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scoreboard bench for cpu_clk_ctrl: expected cpu_en pulses and display strobes are
// queued when stimulus is driven and matched by a negedge monitor.
module tb_cpu_clk_ctrl;
  localparam int unsigned SCAN_DIV   = 4;
  localparam int unsigned SCROLL_DIV = 8;
  localparam int unsigned RUN_DIV    = 5;
  localparam int unsigned DB_CYCLES  = 3;
  // Edges from the first stable-high button sample to the pulse edge:
  // two synchroniser flops, DB_CYCLES debounce samples, then the FSM edge.
  localparam int unsigned STEP_LAT = 2 + DB_CYCLES;

  typedef struct {
    int unsigned cyc;
    logic [31:0] cnt;
  } pulse_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  cpu_clk_ctrl_if bus ();

  cpu_clk_ctrl #(
    .SCAN_DIV(SCAN_DIV), .SCROLL_DIV(SCROLL_DIV),
    .RUN_DIV(RUN_DIV), .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  pulse_t      pulse_q[$];
  int unsigned scan_q[$];
  int unsigned scroll_q[$];
  bit          tick_watch = 1'b0;
  logic [31:0] exp_cnt = '0;
  pulse_t      pm;
  int unsigned tm;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cpu_en) begin
        if (pulse_q.size() == 0) begin
          check("cpu_en_spurious", 32'd1, 32'd0);
        end else begin
          pm = pulse_q.pop_front();
          check("cpu_en_cycle", cyc, pm.cyc);
          check("cnt_at_pulse", bus.cycle_cnt, pm.cnt);
        end
      end
      if (tick_watch && bus.scan_tick) begin
        if (scan_q.size() == 0) check("scan_spurious", 32'd1, 32'd0);
        else begin
          tm = scan_q.pop_front();
          check("scan_tick_cycle", cyc, tm);
        end
      end
      if (tick_watch && bus.scroll_tick) begin
        if (scroll_q.size() == 0) check("scroll_spurious", 32'd1, 32'd0);
        else begin
          tm = scroll_q.pop_front();
          check("scroll_tick_cycle", cyc, tm);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_en"},  {31'd0, bus.cpu_en},      32'd0);
    check({tag, "_cnt"},     bus.cycle_cnt,            32'd0);
    check({tag, "_scan"},    {31'd0, bus.scan_tick},   32'd0);
    check({tag, "_scroll"},  {31'd0, bus.scroll_tick}, 32'd0);
    check({tag, "_running"}, {31'd0, bus.running},     32'd0);
    check({tag, "_halted"},  {31'd0, bus.halted},      32'd0);
  endtask

  // Releases reset on a negedge and queues the strobes due within `window` edges.
  task automatic release_and_watch(input int unsigned window);
    int unsigned rel;
    rst = 1'b0;
    rel = cyc;
    exp_cnt = '0;
    for (int unsigned k = SCAN_DIV - 1; k <= window; k += SCAN_DIV) scan_q.push_back(rel + k);
    for (int unsigned k = SCROLL_DIV - 1; k <= window; k += SCROLL_DIV) scroll_q.push_back(rel + k);
    tick_watch = 1'b1;
    @(negedge clk);
    check("post_rel_running", {31'd0, bus.running}, 32'd0);
    check("post_rel_halted",  {31'd0, bus.halted},  32'd0);
    repeat (window) @(negedge clk);
    tick_watch = 1'b0;
    check("scan_missing",   scan_q.size(),   32'd0);
    check("scroll_missing", scroll_q.size(), 32'd0);
  endtask

  task automatic step_press(input bit bounce, input bit expect_pulse);
    if (bounce) begin
      bus.btn_step = 1'b1;
      @(negedge clk);
      bus.btn_step = 1'b0;
      @(negedge clk);
    end
    bus.btn_step = 1'b1;
    if (expect_pulse) begin
      pulse_q.push_back('{cyc + 1 + STEP_LAT, exp_cnt});
      exp_cnt = exp_cnt + 32'd1;
    end
    repeat (10) @(negedge clk);
    bus.btn_step = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1);
  end

  int unsigned base;

  initial begin
    bus.btn_step = 1'b0;
    bus.run      = 1'b0;
    bus.halt     = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("in_reset");

    // Idle: strobes only, no CPU enables.
    release_and_watch(20);
    check("idle_cnt", bus.cycle_cnt, 32'd0);

    // Bouncy press: one pulse; held press gives no more; a fresh press gives one.
    step_press(1'b1, 1'b1);
    check("step_cnt", bus.cycle_cnt, 32'd1);
    step_press(1'b0, 1'b1);
    check("step2_cnt", bus.cycle_cnt, 32'd2);
    check("step_pending", pulse_q.size(), 32'd0);

    // Free run for 30 cycles: entry after the synchroniser, a pulse every RUN_DIV.
    base = cyc;
    bus.run = 1'b1;
    for (int unsigned k = 1; RUN_DIV * k <= 30; k++) begin
      pulse_q.push_back('{base + 2 + RUN_DIV * k, exp_cnt});
      exp_cnt = exp_cnt + 32'd1;
    end
    repeat (2) @(negedge clk);
    check("run_entry_early", {31'd0, bus.running}, 32'd0);
    @(negedge clk);
    check("run_entry", {31'd0, bus.running}, 32'd1);
    repeat (27) @(negedge clk);
    bus.run = 1'b0;
    repeat (2) @(negedge clk);
    check("run_exit_late", {31'd0, bus.running}, 32'd1);
    @(negedge clk);
    check("run_exit", {31'd0, bus.running}, 32'd0);
    repeat (10) @(negedge clk);
    check("run_pending", pulse_q.size(), 32'd0);
    check("run_cnt", bus.cycle_cnt, 32'd8);

    // Halt raised exactly when the first RUN pulse is due: it must be suppressed.
    base = cyc;
    bus.run = 1'b1;
    repeat (2 + RUN_DIV - 1) @(negedge clk);
    bus.halt = 1'b1;
    @(negedge clk);
    bus.halt = 1'b0;
    check("halt_halted",  {31'd0, bus.halted},  32'd1);
    check("halt_running", {31'd0, bus.running}, 32'd0);
    bus.run = 1'b0;
    repeat (5) @(negedge clk);
    step_press(1'b0, 1'b0);
    bus.run = 1'b1;
    repeat (10) @(negedge clk);
    bus.run = 1'b0;
    repeat (5) @(negedge clk);
    check("halt_sticky", {31'd0, bus.halted}, 32'd1);
    check("halt_cnt", bus.cycle_cnt, exp_cnt);
    rst = 1'b1;
    #1;
    check("halt_cleared", {31'd0, bus.halted}, 32'd0);
    @(negedge clk);
    release_and_watch(9);

    // Counter wrap.
    force dut.cnt_q = 32'hFFFF_FFFF;
    release dut.cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    check("wrap_preload", bus.cycle_cnt, 32'hFFFF_FFFF);
    step_press(1'b0, 1'b1);
    check("wrap_cnt", bus.cycle_cnt, 32'h0000_0000);

    // Reset two cycles after a RUN pulse.
    base = cyc;
    bus.run = 1'b1;
    for (int unsigned k = 1; k <= 2; k++) begin
      pulse_q.push_back('{base + 2 + RUN_DIV * k, exp_cnt});
      exp_cnt = exp_cnt + 32'd1;
    end
    repeat (2 + 2 * RUN_DIV + 2) @(negedge clk);
    check("pre_rst_running", {31'd0, bus.running}, 32'd1);
    rst = 1'b1;
    bus.run = 1'b0;
    #1;
    check_all_zero("mid_rst");
    check("mid_rst_pending", pulse_q.size(), 32'd0);
    @(negedge clk);
    release_and_watch(9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
